// File: rtl/ym3438_pg_if.sv
// Slot-rate bus into and out of the YM3438 phase generator.
// The master drives the per-slot operator parameters. The slave returns the phase, the slot tag and the debug increment.
interface ym3438_pg_if;
    logic        c1;
    logic        sync;
    logic [11:0] fnum_lfo;
    logic [2:0]  block;
    logic [4:0]  dt_inc;
    logic        dt_sign;
    logic [3:0]  multi;
    logic        key_rst;
    logic [9:0]  phase_o;
    logic [4:0]  slot_o;
    logic [19:0] inc_o;

    modport master (
        output c1, sync, fnum_lfo, block, dt_inc, dt_sign, multi, key_rst,
        input  phase_o, slot_o, inc_o
    );

    modport slave (
        input  c1, sync, fnum_lfo, block, dt_inc, dt_sign, multi, key_rst,
        output phase_o, slot_o, inc_o
    );
endinterface

// File: rtl/ym3438_pg.sv
// YM3438 phase generator: a 3-stage slot pipeline feeding 24 independent 20-bit phase accumulators.
// Stage 1 builds the detuned base frequency. Stage 2 applies the multiplier.
// Stage 3 updates the tagged accumulator and registers the outputs.
module ym3438_pg (
    input  logic            MCLK,
    input  logic            IC,
    ym3438_pg_if.slave      bus
);
    localparam int SLOTS = 24;

    // slot counter holds the slot number the next tick will take when sync is low
    logic [4:0]  cnt_reg;
    logic [4:0]  cur_slot;
    logic [4:0]  cnt_next;

    // stage 1 registers
    logic [16:0] s1_base_reg;
    logic [3:0]  s1_multi_reg;
    logic [4:0]  s1_slot_reg;
    logic        s1_key_reg;

    // stage 2 registers
    logic [19:0] s2_inc_reg;
    logic [4:0]  s2_slot_reg;
    logic        s2_key_reg;

    // output registers
    logic [9:0]  phase_reg;
    logic [4:0]  slot_reg;
    logic [19:0] inc_reg;

    logic [19:0] shifted;
    logic [16:0] base_next;
    logic [19:0] prod;
    logic [19:0] inc_next;
    logic [19:0] acc_cur;
    logic [19:0] acc_next;
    logic [19:0] acc_bus [SLOTS];

    // Slot numbering and the detuned base frequency for the incoming slot.
    always_comb begin
        cur_slot  = bus.sync ? 5'd0 : cnt_reg;
        cnt_next  = (cur_slot == 5'd23) ? 5'd0 : cur_slot + 5'd1;
        shifted   = {8'd0, bus.fnum_lfo} << bus.block;
        base_next = bus.dt_sign ? (shifted[18:2] - {12'd0, bus.dt_inc})
                                : (shifted[18:2] + {12'd0, bus.dt_inc});
    end

    // The multiplier is applied to the registered base. Zero selects the half-rate case.
    always_comb begin
        prod     = {3'd0, s1_base_reg} * {16'd0, s1_multi_reg};
        inc_next = (s1_multi_reg == 4'd0) ? {4'd0, s1_base_reg[16:1]} : prod;
    end

    // The accumulator value for the slot in stage 3. A key reset discards the increment.
    always_comb begin
        acc_cur  = acc_bus[s2_slot_reg];
        acc_next = s2_key_reg ? 20'd0 : acc_cur + s2_inc_reg;
    end

    // The counter and all pipeline registers advance only on slot ticks. IC clears them unconditionally.
    always_ff @(posedge MCLK) begin
        if (IC) begin
            cnt_reg      <= 5'd0;
            s1_base_reg  <= 17'd0;
            s1_multi_reg <= 4'd0;
            s1_slot_reg  <= 5'd0;
            s1_key_reg   <= 1'b0;
            s2_inc_reg   <= 20'd0;
            s2_slot_reg  <= 5'd0;
            s2_key_reg   <= 1'b0;
            phase_reg    <= 10'd0;
            slot_reg     <= 5'd0;
            inc_reg      <= 20'd0;
        end else if (bus.c1) begin
            cnt_reg      <= cnt_next;
            // multi is captured with the rest of the slot's inputs, so a slot's increment uses only the values presented on its own tick
            s1_base_reg  <= base_next;
            s1_multi_reg <= bus.multi;
            s1_slot_reg  <= cur_slot;
            s1_key_reg   <= bus.key_rst;
            s2_inc_reg   <= inc_next;
            s2_slot_reg  <= s1_slot_reg;
            s2_key_reg   <= s1_key_reg;
            phase_reg    <= acc_next[19:10];
            slot_reg     <= s2_slot_reg;
            inc_reg      <= s2_inc_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_acc
            logic [19:0] acc_reg;

            // Each accumulator is written only when the stage-3 slot tag matches its index.
            always_ff @(posedge MCLK) begin
                if (IC) begin
                    acc_reg <= 20'd0;
                end else if (bus.c1 && (s2_slot_reg == 5'(gi))) begin
                    acc_reg <= acc_next;
                end
            end

            assign acc_bus[gi] = acc_reg;
        end
    endgenerate

    assign bus.phase_o = phase_reg;
    assign bus.slot_o  = slot_reg;
    assign bus.inc_o   = inc_reg;
endmodule

// File: tb/tb_ym3438_pg.sv
// Testbench for ym3438_pg. Table vectors check increments against hand-computed constants.
// Hand sequences cover the reset and key-reset cases. Random runs are compared with a slot-queue model.
module tb_ym3438_pg;
    logic clk = 1'b0;
    logic ic  = 1'b1;

    ym3438_pg_if bus ();

    ym3438_pg dut (
        .MCLK (clk),
        .IC   (ic),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] fnum;
        logic [2:0]  block;
        logic [4:0]  dt;
        logic        sign;
        logic [3:0]  multi;
        int          exp_inc;
    } vec_t;

    typedef struct {
        int slot;
        bit key;
        int inc;
    } pend_t;

    int    vec_count  = 0;
    int    fail_count = 0;

    // reference model state
    int    acc_m [24];
    int    nxt_m;
    pend_t pipe_m [$];
    int    exp_phase, exp_slot, exp_inc;

    function automatic int model_inc(int fnum, int block, int dt, bit sign, int multi);
        longint b;
        b = (longint'(fnum) * (longint'(1) << block)) / 4;
        b = sign ? b - dt : b + dt;
        b = b % 131072;
        if (b < 0) b = b + 131072;
        if (multi == 0) return int'(b / 2);
        return int'((b * multi) % 1048576);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 24; i++) acc_m[i] = 0;
        nxt_m = 0;
        pipe_m.delete();
        pipe_m.push_back('{0, 1'b0, 0});
        pipe_m.push_back('{0, 1'b0, 0});
        exp_phase = 0;
        exp_slot  = 0;
        exp_inc   = 0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vec_count++;
        if (act != exp) begin
            fail_count++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply one MCLK cycle, advance the model, and compare all three outputs.
    task automatic cycle(input bit ic_i, input bit c1, input bit sync,
                         input logic [11:0] fnum, input logic [2:0] block,
                         input logic [4:0] dt, input bit sign,
                         input logic [3:0] multi, input bit key);
        pend_t e;
        int    s;
        ic           = ic_i;
        bus.c1       = c1;
        bus.sync     = sync;
        bus.fnum_lfo = fnum;
        bus.block    = block;
        bus.dt_inc   = dt;
        bus.dt_sign  = sign;
        bus.multi    = multi;
        bus.key_rst  = key;
        @(posedge clk);
        #1;
        if (ic_i) begin
            model_reset();
        end else if (c1) begin
            s     = sync ? 0 : nxt_m;
            nxt_m = (s + 1) % 24;
            pipe_m.push_back('{s, key, model_inc(int'(fnum), int'(block), int'(dt), sign, int'(multi))});
            e = pipe_m.pop_front();
            acc_m[e.slot] = e.key ? 0 : (acc_m[e.slot] + e.inc) % 1048576;
            exp_phase = acc_m[e.slot] / 1024;
            exp_slot  = e.slot;
            exp_inc   = e.inc;
        end
        chk("phase", int'(bus.phase_o), exp_phase);
        chk("slot",  int'(bus.slot_o),  exp_slot);
        chk("inc",   int'(bus.inc_o),   exp_inc);
    endtask

    initial begin
        vec_t tbl [8];
        tbl[0] = '{12'h400, 3'd4, 5'd0, 1'b0, 4'd1,  4096};
        tbl[1] = '{12'h400, 3'd4, 5'd0, 1'b0, 4'd0,  2048};
        tbl[2] = '{12'h400, 3'd4, 5'd0, 1'b0, 4'd15, 61440};
        tbl[3] = '{12'h400, 3'd4, 5'd5, 1'b1, 4'd1,  4091};
        tbl[4] = '{12'h400, 3'd4, 5'd5, 1'b0, 4'd1,  4101};
        tbl[5] = '{12'h000, 3'd0, 5'd3, 1'b1, 4'd1,  'h1FFFD};
        tbl[6] = '{12'hFFF, 3'd7, 5'd0, 1'b0, 4'd15, 917024};
        tbl[7] = '{12'h000, 3'd0, 5'd3, 1'b1, 4'd0,  'hFFFE};

        model_reset();
        cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 1, 12'hABC, 3'd5, 5'd7, 1, 4'd3, 1);

        // Table vectors: hold each for 3 ticks so the output reflects it.
        foreach (tbl[i]) begin
            for (int t = 0; t < 3; t++)
                cycle(0, 1, 0, tbl[i].fnum, tbl[i].block, tbl[i].dt, tbl[i].sign, tbl[i].multi, 0);
            chk($sformatf("tbl%0d_inc", i), int'(bus.inc_o), tbl[i].exp_inc);
        end

        // Basic rate from reset: each slot's phase rises by 4 per update.
        cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int t = 0; t < 2 + 24 * 3; t++)
            cycle(0, 1, 0, 12'h400, 3'd4, 5'd0, 0, 4'd1, 0);
        chk("basic_phase_k3", int'(bus.phase_o), 12);

        // Key reset on slot 5 only, then the next slot-5 update restarts from zero.
        for (int t = 0; t < 24; t++) begin
            if (nxt_m == 5) break;
            cycle(0, 1, 0, 12'h400, 3'd4, 5'd0, 0, 4'd1, 0);
        end
        cycle(0, 1, 0, 12'h400, 3'd4, 5'd0, 0, 4'd1, 1);
        cycle(0, 0, 0, 12'h400, 3'd4, 5'd0, 0, 4'd1, 0);
        cycle(0, 1, 0, 12'h400, 3'd4, 5'd0, 0, 4'd1, 0);
        cycle(0, 1, 0, 12'h400, 3'd4, 5'd0, 0, 4'd1, 0);
        chk("keyrst_slot",  int'(bus.slot_o),  5);
        chk("keyrst_phase", int'(bus.phase_o), 0);
        chk("keyrst_inc",   int'(bus.inc_o),   4096);
        for (int t = 0; t < 24; t++)
            cycle(0, 1, 0, 12'h400, 3'd4, 5'd0, 0, 4'd1, 0);
        chk("keyrst_next_slot",  int'(bus.slot_o),  5);
        chk("keyrst_next_phase", int'(bus.phase_o), 4);

        // Accumulator wrap at the largest increment, with occasional idle cycles.
        for (int t = 0; t < 110; t++)
            cycle(0, ($urandom_range(0, 9) != 0), 0, 12'hFFF, 3'd7, 5'd0, 0, 4'd15, 0);

        // Random stimulus with sync, key reset, idle cycles and occasional IC.
        for (int t = 0; t < 600; t++)
            cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 4) != 0),
                  ($urandom_range(0, 19) == 0), 12'($urandom), 3'($urandom),
                  5'($urandom), 1'($urandom), 4'($urandom),
                  ($urandom_range(0, 9) == 0));

        // Reset mid-run, then a zero-input run must produce all-zero outputs.
        cycle(1, 0, 0, 12'h123, 3'd2, 5'd1, 0, 4'd2, 0);
        chk("ic_phase", int'(bus.phase_o), 0);
        chk("ic_slot",  int'(bus.slot_o),  0);
        chk("ic_inc",   int'(bus.inc_o),   0);
        for (int t = 0; t < 26; t++) begin
            cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
            chk("zero_run_phase", int'(bus.phase_o), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
        $finish;
    end
endmodule
